// File: rtl/pixel_byte_serializer_pkg.sv
// Shared definitions for the pixel output serializer: pixel widths,
// the bypass select code, the serializer FSM states and a byte-count helper.
package pixel_byte_serializer_pkg;

    localparam int MAX_PIXEL_BITS  = 24;
    localparam int PIXEL_WIDTH_OUT = 8;

    localparam logic [1:0] SEL_BYPASS = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Number of bytes a queued pixel occupies on the host bus.
    function automatic logic [1:0] pixel_byte_count(input logic rgb);
        logic [1:0] cnt;
        if (rgb) begin
            cnt = 2'd3;
        end else begin
            cnt = 2'd1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pixel_byte_serializer_fifo.sv
// Small synchronous first-word-fall-through FIFO holding queued pixels.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module pixel_fifo
    import pixel_byte_serializer_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full_o    = (r_count == (AW+1)'(DEPTH));
    assign empty_o   = (r_count == {(AW+1){1'b0}});
    assign rd_data_o = r_mem[r_rd_ptr];

    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    // Storage array; contents need no reset because the count gates reads.
    always_ff @(posedge clk_i) begin
        if (w_do_push && !reset_i) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_byte_serializer.sv
// Pixel output transmitter: queues pipeline pixels and sends them to the host
// as bytes over a valid/ack bus (three bytes per pixel in bypass, else one).
module pixel_byte_serializer #(
    parameter int MAX_PIXEL_BITS  = 24,
    parameter int PIXEL_WIDTH_OUT = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [1:0]                select_i,
    input  logic                      px_rdy_i,
    input  logic [MAX_PIXEL_BITS-1:0] in_pixel_i,
    input  logic                      byte_ack_i,
    output logic [PIXEL_WIDTH_OUT-1:0] byte_o,
    output logic                      byte_valid_o,
    output logic                      busy_o,
    output logic                      overflow_o
);

    import pixel_byte_serializer_pkg::*;

    localparam int FW = MAX_PIXEL_BITS + 1;

    ser_state_t                r_state;
    ser_state_t                w_state_next;
    logic [MAX_PIXEL_BITS-1:0] r_shift;
    logic [MAX_PIXEL_BITS-1:0] w_shift_next;
    logic [1:0]                r_bytes_left;
    logic [1:0]                w_bytes_left_next;
    logic                      r_overflow;

    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [FW-1:0]             w_fifo_rd;
    logic                      w_pop;
    logic                      w_head_rgb;
    logic [MAX_PIXEL_BITS-1:0] w_head_px;
    logic [MAX_PIXEL_BITS-1:0] w_head_aligned;

    pixel_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push_i    (px_rdy_i),
        .pop_i     (w_pop),
        .wr_data_i ({select_i == SEL_BYPASS, in_pixel_i}),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty),
        .rd_data_o (w_fifo_rd)
    );

    assign w_head_rgb = w_fifo_rd[MAX_PIXEL_BITS];
    assign w_head_px  = w_fifo_rd[MAX_PIXEL_BITS-1:0];

    // One-byte pixels are moved to the top byte on load so the output always
    // comes from the top of the shift register.
    assign w_head_aligned = w_head_rgb ? w_head_px
                          : {w_head_px[PIXEL_WIDTH_OUT-1:0],
                             {(MAX_PIXEL_BITS-PIXEL_WIDTH_OUT){1'b0}}};

    // Next-state, pop request and shift/count updates for the byte sender.
    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_bytes_left_next = r_bytes_left;
        w_pop             = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop             = 1'b1;
                    w_shift_next      = w_head_aligned;
                    w_bytes_left_next = pixel_byte_count(w_head_rgb);
                    w_state_next      = SEND;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SEND: begin
                if (byte_ack_i) begin
                    if (r_bytes_left > 2'd1) begin
                        w_shift_next      = {r_shift[MAX_PIXEL_BITS-PIXEL_WIDTH_OUT-1:0],
                                             {PIXEL_WIDTH_OUT{1'b0}}};
                        w_bytes_left_next = r_bytes_left - 2'd1;
                    end else if (!w_fifo_empty) begin
                        w_pop             = 1'b1;
                        w_shift_next      = w_head_aligned;
                        w_bytes_left_next = pixel_byte_count(w_head_rgb);
                    end else begin
                        w_bytes_left_next = 2'd0;
                        w_state_next      = IDLE;
                    end
                end else begin
                    w_state_next = SEND;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM state, shift register and remaining-byte counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_shift      <= {MAX_PIXEL_BITS{1'b0}};
            r_bytes_left <= 2'd0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bytes_left <= w_bytes_left_next;
        end
    end

    // Sticky drop flag: a strobe into a full FIFO with no pop on that edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_overflow <= 1'b0;
        end else if (px_rdy_i && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign byte_o       = r_shift[MAX_PIXEL_BITS-1 -: PIXEL_WIDTH_OUT];
    assign byte_valid_o = (r_state == SEND);
    assign busy_o       = (r_state == SEND) || !w_fifo_empty;
    assign overflow_o   = r_overflow;

endmodule

// File: doc/pixel_byte_serializer.md
# pixel_byte_serializer

Output-side transmitter for the grayscale/Sobel pixel pipeline. It accepts processed pixels from the pipeline's `px_rdy`/pixel strobe interface and queues them. It then sends each pixel to the external host over an 8-bit byte bus with a valid/ack handshake:
- 1 byte per pixel in Sobel/grayscale modes.
- 3 bytes per pixel (RGB) in bypass mode.

It sits between the pipeline output and the chip's output pins.

## Interface
Parameters:
- `MAX_PIXEL_BITS`, 24, full pixel width (RGB888).
- `PIXEL_WIDTH_OUT`, 8, byte/gray pixel width.
- `FIFO_DEPTH`, 4, pixel queue entries (power of two).

Ports:
- `clk_i`  in  1  single clock; all logic on rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `select_i`  in  2  pipeline mode; `2'b11` = bypass (3 bytes/pixel), any other value = 1 byte/pixel.
- `px_rdy_i`  in  1  one-cycle strobe; `in_pixel_i` is valid this cycle.
- `in_pixel_i`  in  MAX_PIXEL_BITS  pixel from the pipeline.
- `byte_ack_i`  in  1  host accepts the current byte.
- `byte_o`  out  8  byte to the host.
- `byte_valid_o`  out  1  `byte_o` is valid.
- `busy_o`  out  1  pixels are queued or a transfer is in progress.
- `overflow_o`  out  1  sticky flag; a pixel was dropped.

## Operation
- Push: on an edge with `px_rdy_i=1`, write `{select_i==2'b11, in_pixel_i}` into the FIFO.
  - The mode flag is latched per pixel. A later change on `select_i` never affects queued pixels.
- Full FIFO with `px_rdy_i=1` and no pop on the same edge: drop the pixel and set `overflow_o`.
  - `overflow_o` stays set until reset.
- Push and pop on the same edge with the FIFO full: both take effect and the count is unchanged. No overflow.
- FSM states: `IDLE`, `SEND`.
  - `IDLE`: `byte_valid_o=0`. If the FIFO is not empty: pop the head into a 24-bit shift register, set `bytes_left` to 3 (RGB flag) or 1, then go to `SEND`.
  - `SEND`: `byte_valid_o=1`.
    - RGB: `byte_o` = `shift[23:16]`. One-byte mode: `byte_o` = `shift[7:0]`. Implementers must pre-align on load so one mux serves both cases.
    - On an edge with `byte_ack_i=1` and `bytes_left>1`: shift left 8, decrement `bytes_left`.
    - On an edge with `byte_ack_i=1` and `bytes_left==1`: if the FIFO is not empty, reload from it in the same edge and stay in `SEND` (no bubble); otherwise go to `IDLE`.
- RGB byte order: `[23:16]`, `[15:8]`, `[7:0]`. One-byte modes send `[7:0]` only.
- `busy_o` = (`state==SEND`) OR (FIFO not empty). Combinational from registers.
- Capacity: `FIFO_DEPTH` + 1 pixels in flight (FIFO plus shift register).

## Timing
- Reset: on an edge with `reset_i=1`, from the next cycle:
  - `byte_o=0`, `byte_valid_o=0`, `busy_o=0`, `overflow_o=0`.
  - FIFO is emptied, state is `IDLE`.
  - Applies mid-transfer too: the partial pixel is discarded.
  - `px_rdy_i` is ignored on reset edges.
- Latency: `px_rdy_i` sampled at edge E0, FIFO empty, FSM in `IDLE`. `byte_valid_o=1` in the cycle after E1. The first byte is presented 2 edges after the strobe.
- Handshake rules:
  - A transfer occurs on an edge where `byte_valid_o` and `byte_ack_i` are both 1.
  - While `byte_valid_o=1` and no transfer has occurred, `byte_o` stays stable.
  - `byte_valid_o` never drops without a transfer, except on reset.
  - `byte_ack_i` while `byte_valid_o=0` is ignored.
- Throughput: with `byte_ack_i` held at 1, one byte per cycle, including across pixel boundaries.
- No combinational path from inputs to outputs.

## Structure
- Shared package (alongside existing pipeline parameters):
  - `MAX_PIXEL_BITS`, `PIXEL_WIDTH_OUT`.
  - `SEL_BYPASS = 2'b11`.
  - `ser_state_t` enum {`IDLE`, `SEND`}.
- Sub-module `pixel_fifo`:
  - Synchronous FIFO, parameters `WIDTH`, `DEPTH`.
  - Ports: push, pop, `full`, `empty`, `rd_data` (registered head, first-word-fall-through).
  - Synchronous active-high reset.
  - Instantiated with `WIDTH = MAX_PIXEL_BITS+1`.
- Top contains the FSM, shift register, 2-bit `bytes_left` counter and overflow flag.

## Test plan
- Reset: drive `reset_i=1` for 2 cycles with `px_rdy_i=1` -> all outputs 0, `busy_o=0`, no bytes emitted afterwards.
- Gray mode: `select_i=2'b10`, push `0x123456`, `byte_ack_i=1` -> `byte_valid_o` rises 2 cycles after the strobe, `byte_o=0x56` for exactly 1 cycle, then `IDLE`.
- Bypass: `select_i=2'b11`, push `0xA1B2C3` then `0x0D0E0F` on consecutive cycles, ack held 1 -> bytes `A1,B2,C3,0D,0E,0F` on 6 consecutive cycles.
- Backpressure: RGB pixel `0x445566`, ack low 5 cycles, then pulse ack -> `byte_o=0x44` stable for all 5 cycles, `0x55` only after the pulse.
- Overflow: ack=0, `select_i=2'b00`, push 6 pixels `0x01..0x06` -> `overflow_o=1` after the 6th strobe. Release ack -> bytes `01..05`; `overflow_o` stays 1 until reset.
- Mode change and reset mid-transfer: push `0x112233` with `11`, then `0x0000AA` with `00` -> `11,22,33,AA`. Repeat, asserting reset after byte `22` -> `byte_valid_o=0` the next cycle, `busy_o=0`, no further bytes.
